// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset controller:
// state codes, recognised opcodes and datapath select encodings.
package ctrl_pkg;

  // Controller states (4-bit encoding kept stable for legacy tooling)
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_EXEC_R   = 4'd3;
  localparam logic [3:0] ST_EXEC_I   = 4'd4;
  localparam logic [3:0] ST_MEM_ADDR = 4'd5;
  localparam logic [3:0] ST_MEM_RD   = 4'd6;
  localparam logic [3:0] ST_MEM_WR   = 4'd7;
  localparam logic [3:0] ST_WB_ALU   = 4'd8;
  localparam logic [3:0] ST_WB_MEM   = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_TRAP     = 4'd11;

  // Recognised major opcodes (IR[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States that talk to memory and therefore wait on mem_ready
  function automatic logic isWaitState(input logic [3:0] state);
    return (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ready and flags
// the cycle on which the wait budget runs out without a response.
module mc_wait_timer #(
  parameter int CNT_W    = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count value held during the final permitted wait cycle
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] countReg;

  // Wait-cycle counter; clear has priority so each new memory state starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countReg <= '0;
    end else if (clear) begin
      countReg <= '0;
    end else if (enable) begin
      countReg <= countReg + CNT_W'(1);
    end
  end

  // Expiry only when still waiting, so a response on the last cycle wins
  assign expired = enable && (countReg == LAST_COUNT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared RV32I-subset datapath.
// One state register, a next-state block and a Moore-style output decode;
// memory waits are bounded by mc_wait_timer and end in a sticky trap.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                pc_source,
  output logic                illegal_op,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired
);

  logic [3:0]          stateReg;
  logic [3:0]          stateNext;
  logic                isStoreReg;
  logic                illegalReg;
  logic                busErrReg;
  logic [RETIRE_W-1:0] retiredReg;
  logic                timerClear;
  logic                timerEnable;
  logic                timerExpired;
  logic                retireEvent;
  logic                branchTaken;

  // Only funct3[2] distinguishes the supported branches (BGE vs BEQ)
  logic unusedFunct3;
  assign unusedFunct3 = ^funct3[1:0];

  // Any state change restarts the wait budget; waiting means no response yet
  assign timerClear  = (stateNext != stateReg);
  assign timerEnable = isWaitState(stateReg) && !mem_ready;

  mc_wait_timer #(
    .CNT_W   (CNT_W),
    .WAIT_MAX(WAIT_MAX)
  ) waitTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timerClear),
    .enable (timerEnable),
    .expired(timerExpired)
  );

  assign branchTaken = funct3[2] ? !alu_lt : alu_zero;

  // An instruction completes when leaving its final state
  assign retireEvent = (stateReg == ST_WB_ALU) || (stateReg == ST_WB_MEM) ||
                       (stateReg == ST_BRANCH) || ((stateReg == ST_MEM_WR) && mem_ready);

  // Next-state selection; memory states hold until ready or the wait budget expires
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:     stateNext = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)         stateNext = ST_DECODE;
        else if (timerExpired) stateNext = ST_TRAP;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:          stateNext = ST_EXEC_R;
          OP_ITYPE:          stateNext = ST_EXEC_I;
          OP_LOAD, OP_STORE: stateNext = ST_MEM_ADDR;
          OP_BRANCH:         stateNext = ST_BRANCH;
          default:           stateNext = ST_TRAP;
        endcase
      end
      ST_EXEC_R:   stateNext = ST_WB_ALU;
      ST_EXEC_I:   stateNext = ST_WB_ALU;
      ST_MEM_ADDR: stateNext = isStoreReg ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)         stateNext = ST_WB_MEM;
        else if (timerExpired) stateNext = ST_TRAP;
      end
      ST_MEM_WR: begin
        if (mem_ready)         stateNext = ST_FETCH;
        else if (timerExpired) stateNext = ST_TRAP;
      end
      ST_WB_ALU:   stateNext = ST_FETCH;
      ST_WB_MEM:   stateNext = ST_FETCH;
      ST_BRANCH:   stateNext = ST_FETCH;
      ST_TRAP:     stateNext = ST_TRAP;
      default:     stateNext = ST_IDLE;
    endcase
  end

  // State register, latched load/store class, sticky trap causes and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= ST_IDLE;
      isStoreReg <= 1'b0;
      illegalReg <= 1'b0;
      busErrReg  <= 1'b0;
      retiredReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == ST_DECODE) begin
        isStoreReg <= (opcode == OP_STORE);
      end
      if ((stateReg == ST_DECODE) && (stateNext == ST_TRAP)) begin
        illegalReg <= 1'b1;
      end
      if (isWaitState(stateReg) && (stateNext == ST_TRAP)) begin
        busErrReg <= 1'b1;
      end
      if (retireEvent) begin
        retiredReg <= retiredReg + RETIRE_W'(1);
      end
    end
  end

  assign illegal_op = illegalReg;
  assign bus_err    = busErrReg;
  assign retired    = retiredReg;

  // Datapath controls decoded from state; everything defaults to 0 (IDLE and TRAP)
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    pc_source  = 1'b0;
    case (stateReg)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 1'b1;
        pc_write  = branchTaken;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its expected per-cycle control sequence from the instruction class,
// wait counts and branch condition; opcode is randomised outside DECODE.
module tb_multicycle_controller;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 8;
  localparam int RETIRE_W = 8;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_BAD = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                alu_zero;
  logic                alu_lt;
  logic                mem_ready;
  logic                pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic                mem_to_reg, reg_write, alu_src_a, pc_source;
  logic [1:0]          alu_src_b, alu_op;
  logic                illegal_op, bus_err;
  logic [RETIRE_W-1:0] retired;

  int checks   = 0;
  int failures = 0;

  logic                expIll;
  logic                expBus;
  logic [RETIRE_W-1:0] expRetired;

  logic [12:0] ctlObs;
  assign ctlObs = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  multicycle_controller #(
    .WAIT_MAX(WAIT_MAX),
    .CNT_W   (CNT_W),
    .RETIRE_W(RETIRE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .illegal_op(illegal_op),
    .bus_err   (bus_err),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Control word in the same bit order as ctlObs
  function automatic logic [12:0] cw(input logic pcw, input logic irw, input logic iord,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic rw, input logic a, input logic [1:0] b,
                                     input logic [1:0] op, input logic ps);
    return {pcw, irw, iord, mr, mw, m2r, rw, a, b, op, ps};
  endfunction

  task automatic checkCtl(input string tag, input logic [12:0] exp);
    checks++;
    assert (ctlObs === exp) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, ctlObs, exp);
    end
  endtask

  task automatic checkFlags(input string tag);
    checks++;
    assert ({illegal_op, bus_err, retired} === {expIll, expBus, expRetired}) else begin
      failures++;
      $error("FAIL %s flags observed ill=%b bus=%b ret=%0d expected ill=%b bus=%b ret=%0d",
             tag, illegal_op, bus_err, retired, expIll, expBus, expRetired);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check just after
  task automatic cyc(input string tag, input logic rdy, input logic [12:0] exp,
                     input logic isDec, input logic [6:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = isDec ? op : 7'($urandom);
    #1;
    checkCtl(tag, exp);
    checkFlags(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic resetPulse(input string tag);
    #2;
    rst_n      = 1'b0;
    expIll     = 1'b0;
    expBus     = 1'b0;
    expRetired = '0;
    #1;
    checkCtl({tag, "_in_reset"}, 13'd0);
    checkFlags({tag, "_in_reset"});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCtl({tag, "_idle"}, 13'd0);
    checkFlags({tag, "_idle"});
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Run one instruction: fw/mw are the mem_ready-low cycles in FETCH and MEM_RD/MEM_WR
  task automatic runInstr(input int kind, input int fw, input int mw,
                          input logic [2:0] f3, input logic z, input logic lt);
    logic [6:0] op;
    logic       taken;
    funct3   = f3;
    alu_zero = z;
    alu_lt   = lt;
    case (kind)
      K_R:     op = OPC_R;
      K_I:     op = OPC_I;
      K_LD:    op = OPC_LD;
      K_ST:    op = OPC_ST;
      K_BR:    op = OPC_BR;
      default: op = 7'b1111111;
    endcase
    for (int i = 0; i < fw; i++) cyc("FETCH_wait", 1'b0, cw(0,0,0,1,0,0,0,0,2'b01,2'b00,0), 1'b0, op);
    cyc("FETCH", 1'b1, cw(1,1,0,1,0,0,0,0,2'b01,2'b00,0), 1'b0, op);
    cyc("DECODE", rbit(), cw(0,0,0,0,0,0,0,0,2'b10,2'b00,0), 1'b1, op);
    case (kind)
      K_R: begin
        cyc("EXEC_R", rbit(), cw(0,0,0,0,0,0,0,1,2'b00,2'b10,0), 1'b0, op);
        cyc("WB_ALU", rbit(), cw(0,0,0,0,0,0,1,0,2'b00,2'b00,0), 1'b0, op);
        expRetired = expRetired + 1'b1;
      end
      K_I: begin
        cyc("EXEC_I", rbit(), cw(0,0,0,0,0,0,0,1,2'b10,2'b00,0), 1'b0, op);
        cyc("WB_ALU", rbit(), cw(0,0,0,0,0,0,1,0,2'b00,2'b00,0), 1'b0, op);
        expRetired = expRetired + 1'b1;
      end
      K_LD: begin
        cyc("MEM_ADDR", rbit(), cw(0,0,0,0,0,0,0,1,2'b10,2'b00,0), 1'b0, op);
        for (int i = 0; i < mw; i++) cyc("MEM_RD_wait", 1'b0, cw(0,0,1,1,0,0,0,0,2'b00,2'b00,0), 1'b0, op);
        cyc("MEM_RD", 1'b1, cw(0,0,1,1,0,0,0,0,2'b00,2'b00,0), 1'b0, op);
        cyc("WB_MEM", rbit(), cw(0,0,0,0,0,1,1,0,2'b00,2'b00,0), 1'b0, op);
        expRetired = expRetired + 1'b1;
      end
      K_ST: begin
        cyc("MEM_ADDR", rbit(), cw(0,0,0,0,0,0,0,1,2'b10,2'b00,0), 1'b0, op);
        for (int i = 0; i < mw; i++) cyc("MEM_WR_wait", 1'b0, cw(0,0,1,0,1,0,0,0,2'b00,2'b00,0), 1'b0, op);
        cyc("MEM_WR", 1'b1, cw(0,0,1,0,1,0,0,0,2'b00,2'b00,0), 1'b0, op);
        expRetired = expRetired + 1'b1;
      end
      K_BR: begin
        taken = f3[2] ? !lt : z;
        cyc("BRANCH", rbit(), cw(taken,0,0,0,0,0,0,1,2'b00,2'b01,1), 1'b0, op);
        expRetired = expRetired + 1'b1;
      end
      default: begin
        expIll = 1'b1;
      end
    endcase
  endtask

  // Bounded run time in case the clocked stepping ever stalls
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    opcode     = '0;
    funct3     = '0;
    alu_zero   = 1'b0;
    alu_lt     = 1'b0;
    mem_ready  = 1'b0;
    expIll     = 1'b0;
    expBus     = 1'b0;
    expRetired = '0;

    // Reset state and the IDLE cycle after release
    #3;
    checkCtl("reset", 13'd0);
    checkFlags("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCtl("idle", 13'd0);
    checkFlags("idle");

    // R-type with ready tied high, then a load with three MEM_RD wait cycles
    runInstr(K_R, 0, 0, 3'b000, 1'b0, 1'b0);
    runInstr(K_LD, 0, 3, 3'b010, 1'b0, 1'b0);
    // BGE taken (alu_lt=0), BEQ not taken (alu_zero=0)
    runInstr(K_BR, 0, 0, 3'b101, 1'b0, 1'b0);
    runInstr(K_BR, 0, 0, 3'b000, 1'b0, 1'b1);
    runInstr(K_I, 0, 0, 3'b000, 1'b0, 1'b0);
    runInstr(K_ST, 0, 0, 3'b010, 1'b0, 1'b0);
    // Ready arrives on the last permitted wait cycle: no trap
    runInstr(K_R, WAIT_MAX - 1, 0, 3'b000, 1'b0, 1'b0);
    runInstr(K_ST, 0, WAIT_MAX - 1, 3'b010, 1'b0, 1'b0);

    // Fetch timeout: WAIT_MAX cycles without ready traps with bus_err
    for (int i = 0; i < WAIT_MAX; i++) cyc("FETCH_timeout", 1'b0, cw(0,0,0,1,0,0,0,0,2'b01,2'b00,0), 1'b0, 7'd0);
    expBus = 1'b1;
    for (int i = 0; i < 5; i++) cyc("TRAP_bus", rbit(), 13'd0, 1'b0, 7'd0);
    resetPulse("bus_clear");

    // Illegal opcode: absorbing trap for 20 cycles, retired frozen
    runInstr(K_R, 0, 0, 3'b000, 1'b0, 1'b0);
    runInstr(K_BAD, 0, 0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("TRAP_illegal", rbit(), 13'd0, 1'b0, OPC_R);
    resetPulse("illegal_clear");

    // Asynchronous reset in the middle of a store wait
    runInstr(K_I, 0, 0, 3'b000, 1'b0, 1'b0);
    funct3 = 3'b010;
    cyc("FETCH", 1'b1, cw(1,1,0,1,0,0,0,0,2'b01,2'b00,0), 1'b0, 7'd0);
    cyc("DECODE", 1'b0, cw(0,0,0,0,0,0,0,0,2'b10,2'b00,0), 1'b1, OPC_ST);
    cyc("MEM_ADDR", 1'b0, cw(0,0,0,0,0,0,0,1,2'b10,2'b00,0), 1'b0, 7'd0);
    cyc("MEM_WR_wait", 1'b0, cw(0,0,1,0,1,0,0,0,2'b00,2'b00,0), 1'b0, 7'd0);
    resetPulse("async_mid_store");

    // Random legal instructions; enough to wrap the 8-bit retire counter
    for (int n = 0; n < 280; n++) begin
      runInstr(int'($urandom_range(0, 4)), int'($urandom_range(0, WAIT_MAX - 1)),
               int'($urandom_range(0, WAIT_MAX - 1)), 3'($urandom), rbit(), rbit());
    end
    cyc("FETCH_final", 1'b0, cw(0,0,0,1,0,0,0,0,2'b01,2'b00,0), 1'b0, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
